uc_bcast_scheduler: RTL and testbench
=====================================

UC_BCAST_SCHEDULER -- requirements
Module: uc_bcast_scheduler

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset; all state is sampled on posedge clk.
REQ-002 SHALL provide these ports (`NUM_ENGINE and lit_t are taken from the codebase defines):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- uca2ucb_lit  in  lit_t  literal from the UC arbiter
- uca2ucb_push  in  1  enqueue request
- ucb2uca_full  out  1  scheduler cannot accept a literal
- eng2ucb_full  in  `NUM_ENGINE  per-engine UCQ_IN full
- ucb2eng_lit  out  lit_t  literal being broadcast (FIFO head)
- ucb2eng_push  out  `NUM_ENGINE  per-engine push strobe
- flush  in  1  conflict/backtrack flush
- ucb_idle  out  1  FIFO empty and state IDLE
- ucb_count  out  3  FIFO occupancy, 0..4
- ucb_overflow  out  1  sticky: push seen while full

Function
REQ-003 SHALL buffer literals in a 4-entry FIFO with a 2-bit read pointer and a 2-bit write pointer, both wrapping modulo 4, and a 3-bit count.
REQ-004 SHALL drive ucb2uca_full = (count==4) OR (state==FLUSH), combinationally.
REQ-005 SHALL enqueue uca2ucb_lit when uca2ucb_push=1 and ucb2uca_full=0; SHALL drop a push while full and set ucb_overflow.
REQ-006 SHALL implement three FSM states:
- IDLE: count==0
- BCAST: count>0
- FLUSH: one cycle after flush
REQ-007 IDLE->BCAST SHALL occur on the cycle after the first enqueue; BCAST->IDLE SHALL occur when the last entry retires with no simultaneous enqueue.
REQ-008 SHALL keep a `NUM_ENGINE-bit sent_mask recording which engines have accepted the current head.
REQ-009 In BCAST, for each engine i, ucb2eng_push[i] SHALL equal (!sent_mask[i] AND !eng2ucb_full[i]); in IDLE and FLUSH, ucb2eng_push SHALL be 0.
REQ-010 ucb2eng_lit SHALL equal the FIFO head in all states, and SHALL be 0 when count==0.
REQ-011 When (sent_mask | ucb2eng_push) is all ones, the head SHALL retire that cycle:
- read pointer advances
- count decrements
- sent_mask clears to 0
REQ-012 If the head does not retire, sent_mask SHALL be updated to sent_mask | ucb2eng_push.
REQ-013 Latency: a literal enqueued into an empty FIFO at cycle t SHALL be pushed no earlier than cycle t+1; each head occupies at least one cycle.
REQ-014 A simultaneous enqueue and retire SHALL leave count unchanged; with count==4, the full flag blocks the enqueue even when a retire occurs that cycle.
REQ-015 flush SHALL have priority over push and retire:
- pointers, count and sent_mask clear
- no ucb2eng_push is asserted in the flush cycle
- the next state is FLUSH, then IDLE
REQ-016 ucb_idle SHALL be 1 only when state==IDLE and count==0.

Reset
REQ-017 On rst=1 at posedge clk, the block SHALL enter IDLE with pointers, count and sent_mask at 0 and ucb_overflow at 0.
REQ-018 During and after reset: ucb2eng_push=0, ucb2eng_lit=0, ucb2uca_full=0, ucb_idle=1, ucb_count=0.
REQ-019 Reset mid-broadcast SHALL discard all buffered literals and partial sent_mask state without asserting any push in the reset cycle.

Configuration
REQ-020 SHALL support the macro UCB_DEDUP_EN.
REQ-021 With UCB_DEDUP_EN defined:
- the block holds last_lit and a last_valid flag
- an accepted push whose literal equals last_lit while last_valid=1 is discarded: not enqueued, count unchanged, no overflow
- last_lit/last_valid update on every enqueue
- last_valid clears on reset and flush
REQ-022 Without UCB_DEDUP_EN, every accepted push SHALL be enqueued, and no last_lit storage SHALL exist.

Verification (`NUM_ENGINE=4)
REQ-023 Push 0x05 with no engine full -> next cycle ucb2eng_push=4'b1111 and ucb2eng_lit=0x05; the following cycle count=0 and ucb_idle=1.
REQ-024 Push 0x07 with eng2ucb_full=4'b0100 for 3 cycles -> push=4'b1011, then 0000 for two cycles, then 4'b0100 when full drops; retire on that cycle; engine 2 receives exactly one push.
REQ-025 Push 5 literals back-to-back with eng2ucb_full=4'b1111 -> count reaches 4, ucb2uca_full=1, the 5th push is dropped, ucb_overflow=1 until reset.
REQ-026 Buffer 3 literals, assert flush during a partial broadcast (sent_mask=4'b0011) -> no push in that cycle, the next cycle has ucb2uca_full=1 (FLUSH), then IDLE with count=0.
REQ-027 With UCB_DEDUP_EN, push 0x09, 0x09, 0x0A -> count=2 and the broadcast order is 0x09 then 0x0A; without the macro, count=3.
REQ-028 Assert rst while count=2 and engine 1 is full -> the next cycle all outputs are at reset values and ucb_overflow=0.

Source files
------------

// File: rtl/uc_bcast_scheduler.sv
// uc_bcast_scheduler: 4-entry literal FIFO whose head is broadcast to every engine and retires once all have taken it.
// Optional build macro UCB_DEDUP_EN discards a push that repeats the most recently enqueued literal.
`ifndef NUM_ENGINE
`define NUM_ENGINE 4
`endif
`ifndef LIT_W
`define LIT_W 8
`endif

package ucb_pkg;
    typedef logic [`LIT_W-1:0] lit_t;
endpackage

module uc_bcast_scheduler (
    input  logic                   clk,
    input  logic                   rst,
    input  ucb_pkg::lit_t          uca2ucb_lit,
    input  logic                   uca2ucb_push,
    output logic                   ucb2uca_full,
    input  logic [`NUM_ENGINE-1:0] eng2ucb_full,
    output ucb_pkg::lit_t          ucb2eng_lit,
    output logic [`NUM_ENGINE-1:0] ucb2eng_push,
    input  logic                   flush,
    output logic                   ucb_idle,
    output logic [2:0]             ucb_count,
    output logic                   ucb_overflow
);
    import ucb_pkg::*;

    localparam int NE = `NUM_ENGINE;

    typedef enum logic [1:0] {S_IDLE, S_BCAST, S_FLUSH} state_t;

    state_t          r_state, w_state_next;
    lit_t            r_mem [4];
    logic [1:0]      r_rd_ptr, r_wr_ptr;
    logic [2:0]      r_count;
    logic [NE-1:0]   r_sent_mask;
    logic            r_overflow;
    logic            w_full, w_dup, w_enq, w_retire;
    logic [NE-1:0]   w_push;

    // FLUSH reports full so nothing can slip in while the queue is being emptied.
    assign w_full = (r_count == 3'd4) || (r_state == S_FLUSH);

`ifdef UCB_DEDUP_EN
    lit_t r_last_lit;
    logic r_last_valid;

    assign w_dup = r_last_valid && (uca2ucb_lit == r_last_lit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_lit   <= '0;
            r_last_valid <= 1'b0;
        end else if (flush) begin
            r_last_valid <= 1'b0;
        end else if (w_enq) begin
            r_last_lit   <= uca2ucb_lit;
            r_last_valid <= 1'b1;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    assign w_enq = uca2ucb_push && !w_full && !flush && !w_dup;

    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_push       = '0;
        w_retire     = 1'b0;
        w_state_next = r_state;
        if (r_state == S_BCAST && !flush && !rst)
            w_push = ~r_sent_mask & ~eng2ucb_full;
        w_retire = (r_state == S_BCAST) && !flush && !rst && ((r_sent_mask | w_push) == '1);
        if (flush) begin
            w_state_next = S_FLUSH;
        end else begin
            case (r_state)
                S_IDLE:  if (w_enq) w_state_next = S_BCAST;
                S_BCAST: if (w_retire && !w_enq && r_count == 3'd1) w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_sent_mask <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (uca2ucb_push && w_full)
                r_overflow <= 1'b1;
            if (flush) begin
                r_rd_ptr    <= '0;
                r_wr_ptr    <= '0;
                r_count     <= '0;
                r_sent_mask <= '0;
            end else begin
                if (w_enq)
                    r_wr_ptr <= r_wr_ptr + 2'd1;
                if (w_retire) begin
                    r_rd_ptr    <= r_rd_ptr + 2'd1;
                    r_sent_mask <= '0;
                end else begin
                    r_sent_mask <= r_sent_mask | w_push;
                end
                case ({w_enq, w_retire})
                    2'b10:   r_count <= r_count + 3'd1;
                    2'b01:   r_count <= r_count - 3'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // NOTE: FIFO storage is not reset; count gates every read so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (w_enq)
            r_mem[r_wr_ptr] <= uca2ucb_lit;
    end

    // Outputs are forced to idle values while rst is high so a mid-broadcast reset cannot leak a push.
    assign ucb2uca_full = !rst && w_full;
    assign ucb2eng_push = w_push;
    assign ucb2eng_lit  = (rst || r_count == 3'd0) ? '0 : r_mem[r_rd_ptr];
    assign ucb_idle     = rst || (r_state == S_IDLE && r_count == 3'd0);
    assign ucb_count    = rst ? 3'd0 : r_count;
    assign ucb_overflow = r_overflow;

endmodule

// File: tb/tb_uc_bcast_scheduler.sv
// Directed bench for uc_bcast_scheduler with 4 engines and 8-bit literals; expected values are hand-computed.
`ifndef NUM_ENGINE
`define NUM_ENGINE 4
`endif
`ifndef LIT_W
`define LIT_W 8
`endif

module tb_uc_bcast_scheduler;
    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       uca2ucb_lit;
    logic             uca2ucb_push;
    logic             ucb2uca_full;
    logic [3:0]       eng2ucb_full;
    logic [7:0]       ucb2eng_lit;
    logic [3:0]       ucb2eng_push;
    logic             flush;
    logic             ucb_idle;
    logic [2:0]       ucb_count;
    logic             ucb_overflow;

    int n_cmp = 0;
    int n_err = 0;
    int e2_pushes = 0;

    uc_bcast_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .uca2ucb_lit  (uca2ucb_lit),
        .uca2ucb_push (uca2ucb_push),
        .ucb2uca_full (ucb2uca_full),
        .eng2ucb_full (eng2ucb_full),
        .ucb2eng_lit  (ucb2eng_lit),
        .ucb2eng_push (ucb2eng_push),
        .flush        (flush),
        .ucb_idle     (ucb_idle),
        .ucb_count    (ucb_count),
        .ucb_overflow (ucb_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (ucb2eng_push[2]) e2_pushes = e2_pushes + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then driven and settle before checks.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_push"}, ucb2eng_push, 4'b0000);
        check({tag, "_lit"},  ucb2eng_lit,  8'h00);
        check({tag, "_full"}, ucb2uca_full, 1'b0);
        check({tag, "_idle"}, ucb_idle,     1'b1);
        check({tag, "_cnt"},  ucb_count,    3'd0);
    endtask

    initial begin
        rst = 1'b1; uca2ucb_lit = '0; uca2ucb_push = 1'b0; eng2ucb_full = '0; flush = 1'b0;
        cyc(); settle();
        check_quiet("rst_during");
        cyc(); rst = 1'b0; settle();
        check_quiet("rst_after");
        check("rst_ovf", ucb_overflow, 1'b0);

        // Single literal, all engines free
        uca2ucb_push = 1'b1; uca2ucb_lit = 8'h05; settle();
        check("t1_idle_push", ucb2eng_push, 4'b0000);
        cyc(); uca2ucb_push = 1'b0; settle();
        check("t1_push", ucb2eng_push, 4'b1111);
        check("t1_lit",  ucb2eng_lit,  8'h05);
        check("t1_cnt",  ucb_count,    3'd1);
        check("t1_idle", ucb_idle,     1'b0);
        cyc(); settle();
        check_quiet("t1_done");

        // Engine 2 stalls for three broadcast cycles
        eng2ucb_full = 4'b0100; uca2ucb_push = 1'b1; uca2ucb_lit = 8'h07;
        cyc(); uca2ucb_push = 1'b0; e2_pushes = 0; settle();
        check("t2_push_a", ucb2eng_push, 4'b1011);
        check("t2_lit",    ucb2eng_lit,  8'h07);
        cyc(); settle();
        check("t2_push_b", ucb2eng_push, 4'b0000);
        cyc(); settle();
        check("t2_push_c", ucb2eng_push, 4'b0000);
        cyc(); eng2ucb_full = 4'b0000; settle();
        check("t2_push_d", ucb2eng_push, 4'b0100);
        check("t2_cnt_d",  ucb_count,    3'd1);
        cyc(); settle();
        check("t2_cnt_end", ucb_count, 3'd0);
        check("t2_idle",    ucb_idle,  1'b1);
        check("t2_e2_once", e2_pushes, 1);

        // Fill to four, drop the fifth, then retire with a blocked push
        eng2ucb_full = 4'b1111; uca2ucb_push = 1'b1;
        for (int i = 0; i < 4; i++) begin
            uca2ucb_lit = 8'h10 + 8'(i);
            cyc();
        end
        uca2ucb_lit = 8'h14; settle();
        check("t3_cnt4",  ucb_count,    3'd4);
        check("t3_full",  ucb2uca_full, 1'b1);
        check("t3_ovf0",  ucb_overflow, 1'b0);
        cyc(); settle();
        check("t3_cnt_drop", ucb_count,    3'd4);
        check("t3_ovf1",     ucb_overflow, 1'b1);
        check("t3_head",     ucb2eng_lit,  8'h10);
        check("t3_nopush",   ucb2eng_push, 4'b0000);
        eng2ucb_full = 4'b0000; uca2ucb_lit = 8'h15; settle();
        check("t3_ret_push", ucb2eng_push, 4'b1111);
        cyc(); uca2ucb_lit = 8'h16; settle();
        check("t3_cnt3",  ucb_count,   3'd3);
        check("t3_head2", ucb2eng_lit, 8'h11);
        cyc(); uca2ucb_push = 1'b0; settle();
        check("t3_swap_cnt", ucb_count,   3'd3);
        check("t3_head3",    ucb2eng_lit, 8'h12);
        cyc(); settle();
        check("t3_head4", ucb2eng_lit, 8'h13);
        cyc(); settle();
        check("t3_head5", ucb2eng_lit, 8'h16);
        check("t3_cnt1",  ucb_count,   3'd1);
        cyc(); settle();
        check("t3_idle",    ucb_idle,     1'b1);
        check("t3_ovf_stk", ucb_overflow, 1'b1);

        // Flush during a partial broadcast
        eng2ucb_full = 4'b1111; uca2ucb_push = 1'b1;
        for (int i = 0; i < 3; i++) begin
            uca2ucb_lit = 8'h20 + 8'(i);
            cyc();
        end
        uca2ucb_push = 1'b0; eng2ucb_full = 4'b1100; settle();
        check("t4_part", ucb2eng_push, 4'b0011);
        cyc(); eng2ucb_full = 4'b0000; flush = 1'b1; settle();
        check("t4_fl_push", ucb2eng_push, 4'b0000);
        check("t4_fl_cnt",  ucb_count,    3'd3);
        cyc(); flush = 1'b0; settle();
        check("t4_st_full", ucb2uca_full, 1'b1);
        check("t4_st_cnt",  ucb_count,    3'd0);
        check("t4_st_push", ucb2eng_push, 4'b0000);
        check("t4_st_idle", ucb_idle,     1'b0);
        cyc(); settle();
        check_quiet("t4_after");

        // Repeated literal: deduplicated only when the option is built in
        eng2ucb_full = 4'b1111; uca2ucb_push = 1'b1;
        uca2ucb_lit = 8'h09; cyc();
        uca2ucb_lit = 8'h09; cyc();
        uca2ucb_lit = 8'h0A; cyc();
        uca2ucb_push = 1'b0; settle();
`ifdef UCB_DEDUP_EN
        check("t5_cnt", ucb_count, 3'd2);
`else
        check("t5_cnt", ucb_count, 3'd3);
`endif
        check("t5_ovf", ucb_overflow, 1'b1);
        eng2ucb_full = 4'b0000; settle();
        check("t5_head1", ucb2eng_lit, 8'h09);
        cyc(); settle();
`ifdef UCB_DEDUP_EN
        check("t5_head2", ucb2eng_lit, 8'h0A);
`else
        check("t5_head2", ucb2eng_lit, 8'h09);
        cyc(); settle();
        check("t5_head3", ucb2eng_lit, 8'h0A);
`endif
        cyc(); settle();
        check("t5_idle", ucb_idle, 1'b1);

        // Reset mid-broadcast with engine 1 full
        eng2ucb_full = 4'b0010; uca2ucb_push = 1'b1; uca2ucb_lit = 8'h30;
        cyc(); uca2ucb_lit = 8'h31; settle();
        check("t6_push", ucb2eng_push, 4'b1101);
        cyc(); uca2ucb_push = 1'b0; settle();
        check("t6_cnt2", ucb_count,    3'd2);
        check("t6_mask", ucb2eng_push, 4'b0000);
        rst = 1'b1; settle();
        check("t6_rst_push", ucb2eng_push, 4'b0000);
        cyc(); rst = 1'b0; settle();
        check_quiet("t6_after");
        check("t6_ovf", ucb_overflow, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
